// File: rtl/pcint3_ctrl.sv
// -----------------------------------------------------------------------------
// pcint3_ctrl
//   Pin-change interrupt controller for the 4-pin Port E group (PCINT[27:24]).
//   Owns PCMSK3, PCICR.PCIE3 and PCIFR.PCIF3 on the IO bus. It synchronises and
//   edge-detects pinE_i, then raises and clears the PCINT3 request.
//
//   Build option:
//     PCINT_GLITCH_FILTER_EN - when defined, adds a third synchroniser stage.
//       A pin counts as changed only after it has been stable for two samples.
//       Pulses shorter than two cycles are then ignored, and latency grows by
//       one cycle.
//
// Ports
//   cp2       in   1  system clock, rising edge
//   ireset    in   1  asynchronous reset, active-high
//   IO_Addr   in   6  IO address
//   iore      in   1  IO read strobe
//   iowe      in   1  IO write strobe
//   dbus_in   in   8  IO write data
//   dbus_out  out  8  IO read data (8'h00 when out_en=0)
//   out_en    out  1  iore & address hit on PCMSK3/PCICR/PCIFR
//   pinE_i    in   4  raw Port E pin levels (asynchronous)
//   PCINT     out  4  PCMSK3[3:0], to Port E (digital-input-enable override)
//   PCIE3     out  1  PCICR bit3, to Port E
//   irq       out  1  PCIF3 & PCIE3
//   irq_ack   in   1  one-cycle pulse when the vector is taken
// -----------------------------------------------------------------------------
module pcint3_ctrl #(
    parameter logic [5:0] PCMSK_Address = 6'h2B,
    parameter logic [5:0] PCICR_Address = 6'h28,
    parameter logic [5:0] PCIFR_Address = 6'h1B
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] IO_Addr,
    input  logic       iore,
    input  logic       iowe,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       out_en,
    input  logic [3:0] pinE_i,
    output logic [3:0] PCINT,
    output logic       PCIE3,
    output logic       irq,
    input  logic       irq_ack
);

`ifdef PCINT_GLITCH_FILTER_EN
    localparam logic [1:0] SETTLE_INIT = 2'd3;
`else
    localparam logic [1:0] SETTLE_INIT = 2'd2;
`endif

    logic [3:0] pcmsk_q;
    logic       pcie3_q;
    logic       pcif3_q;
    logic [3:0] s1_q, s2_q, prev_q;
    logic [1:0] settle_q;
    logic [3:0] changed, prev_d, chg;
    logic       sel_pcmsk, sel_pcicr, sel_pcifr;
    logic [7:0] rd_data;
    logic       unused_bits;

    // Only bit 3 and the low nibble of the write bus carry register data.
    assign unused_bits = ^dbus_in[7:4];

    assign sel_pcmsk = (IO_Addr == PCMSK_Address);
    assign sel_pcicr = (IO_Addr == PCICR_Address);
    assign sel_pcifr = (IO_Addr == PCIFR_Address);

    // ------------------------------------------------------------------ sync
    // prev tracks every pin regardless of mask. Unmasking a pin that already
    // sits at a new level therefore never looks like a change.
`ifdef PCINT_GLITCH_FILTER_EN
    logic [3:0] s3_q;
    logic [3:0] stable;

    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) s3_q <= '0;
        else        s3_q <= s2_q;
    end

    // A pin is accepted only when two consecutive samples agree. prev follows
    // only accepted levels, so a one-cycle glitch never reaches prev.
    always_comb begin
        stable  = ~(s2_q ^ s3_q);
        changed = stable & (s3_q ^ prev_q);
        prev_d  = (stable & s3_q) | (~stable & prev_q);
    end
`else
    always_comb begin
        changed = s2_q ^ prev_q;
        prev_d  = s2_q;
    end
`endif

    // Edge detection stays blind until the synchroniser has filled after reset.
    assign chg = changed & pcmsk_q & {4{settle_q == 2'd0}};

    // NOTE: every clocked block uses non-blocking assignments. All flops then
    // sample pre-edge values, which is what lets s1 -> s2 -> prev act as a shift.
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            settle_q <= SETTLE_INIT;
        end else begin
            s1_q   <= pinE_i;
            s2_q   <= s1_q;
            prev_q <= prev_d;
            if (settle_q != 2'd0)
                settle_q <= settle_q - 2'd1;
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            pcmsk_q <= '0;
            pcie3_q <= 1'b0;
            pcif3_q <= 1'b0;
        end else begin
            // chg above still sees the old mask during the cycle of a write.
            if (iowe && sel_pcmsk)
                pcmsk_q <= dbus_in[3:0];
            if (iowe && sel_pcicr)
                pcie3_q <= dbus_in[3];
            // A new change outranks any clear in the same cycle, so an event
            // arriving as the vector is taken is not lost.
            if (|chg)
                pcif3_q <= 1'b1;
            else if (irq_ack || (iowe && sel_pcifr && dbus_in[3]))
                pcif3_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ read
    // NOTE: rd_data gets a default before any branch. Otherwise an
    // unaddressed read would hold its value and infer a latch.
    always_comb begin
        rd_data = 8'h00;
        if (sel_pcmsk)
            rd_data = {4'h0, pcmsk_q};
        else if (sel_pcicr)
            rd_data = {4'h0, pcie3_q, 3'b000};
        else if (sel_pcifr)
            rd_data = {4'h0, pcif3_q, 3'b000};
    end

    assign out_en   = iore && (sel_pcmsk || sel_pcicr || sel_pcifr);
    assign dbus_out = out_en ? rd_data : 8'h00;

    assign PCINT = pcmsk_q;
    assign PCIE3 = pcie3_q;
    assign irq   = pcif3_q & pcie3_q;

endmodule
